regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file, with a one-cycle write
// pipeline and a pending-write scoreboard consulted by decode.
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 claim_valid,
  input  logic [4:0]           claim_addr,
  output logic                 wen,
  output logic [4:0]           waddr,
  output logic [31:0]          wdata,
  output logic [31:0]          pending
);

  logic [1:0]  rrPtr_q, rrPtr_d;
  logic        gntValid;
  logic [1:0]  gntIdx;
  logic [2:0]  cand;
  logic [4:0]  selAddr;
  logic [31:0] selData;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [31:0] pending_q, pending_d;

  // Scan requesters starting at rrPtr_q, wrapping modulo NREQ; first valid wins.
  always_comb begin
    gntValid = 1'b0;
    gntIdx   = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rrPtr_q} + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!gntValid && !rst && cand == 3'(i) && req_valid[i]) begin
          gntValid = 1'b1;
          gntIdx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    selAddr   = '0;
    selData   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gntValid && gntIdx == 2'(i)) begin
        req_ready[i] = 1'b1;
        selAddr      = req_addr[i*5 +: 5];
        selData      = req_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (gntValid) begin
      rrPtr_d = (gntIdx == 2'(NREQ-1)) ? 2'd0 : gntIdx + 2'd1;
    end
  end

  // Clear on retire first, then set on claim, so a same-cycle claim wins.
  always_comb begin
    pending_d = pending_q;
    if (gntValid) pending_d[selAddr] = 1'b0;
    if (claim_valid) pending_d[claim_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q   <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      pending_q <= pending_d;
      wen_q     <= gntValid && (selAddr != 5'd0);
      if (gntValid) begin
        waddr_q <= selAddr;
        wdata_q <= selData;
      end
    end
  end

  assign wen     = wen_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign pending = pending_q;

endmodule
